// File: rtl/wb_pkg.sv
// Shared types for the integer register file writeback path.
//   reg_idx_t : architectural register index (x0..x31)
//   wb_req_t  : one pending register write (destination + data)
//   REG_ZERO  : index of the hard-wired zero register
package wb_pkg;

  typedef logic [4:0] reg_idx_t;

  typedef struct packed {
    reg_idx_t    rd;
    logic [31:0] data;
  } wb_req_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_resp_fifo.sv
// Circular buffer holding long-latency responses waiting for the write port.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
//   clk_i, rst_ni : clock, synchronous active-low reset (empties the buffer)
//   push_i        : enqueue push_data_i (ignored when full)
//   pop_i         : dequeue the head (ignored when empty)
//   full_o        : no free entry
//   empty_o       : no valid entry
//   head_o        : oldest entry, valid when !empty_o
module wb_resp_fifo
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  input  logic    push_i,
  input  wb_req_t push_data_i,
  input  logic    pop_i,
  output logic    full_o,
  output logic    empty_o,
  output wb_req_t head_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PtrOne = (AW + 1)'(1);

  logic [AW:0] wptr_q, wptr_d;
  logic [AW:0] rptr_q, rptr_d;
  wb_req_t     mem_q [DEPTH];
  logic        do_push;
  logic        do_pop;

  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign head_o  = mem_q[rptr_q[AW-1:0]];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PtrOne;
    if (do_pop)  rptr_d = rptr_q + PtrOne;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage needs no reset: entries are only observed between push and pop.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= push_data_i;
  end

endmodule

// File: rtl/wb_writeback_unit.sv
// Writer side of the integer register file. Merges the in-order ALU result
// with buffered long-latency responses onto the single write port, forces a
// starved response through after STARVE_LIMIT lost cycles, and tracks pending
// long-latency destinations for decode hazard stalls.
//   clk, rst              : clock, synchronous active-low reset
//   alu_*                 : in-order pipeline result; alu_stall = not taken
//   lat_issue_*           : long-latency op issued (sets busy bit)
//   lat_resp_*            : long-latency response, valid/ready handshake
//   W_wb_en_f/index/data  : registered register file write port
//   busy_mask             : bit i set while a long-latency write to x[i] pends
module wb_writeback_unit
  import wb_pkg::*;
#(
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_stall,
  input  logic        lat_issue_valid,
  input  logic [4:0]  lat_issue_rd,
  input  logic        lat_resp_valid,
  output logic        lat_resp_ready,
  input  logic [4:0]  lat_resp_rd,
  input  logic [31:0] lat_resp_data,
  output logic        W_wb_en_f,
  output logic [4:0]  W_rd_index_f,
  output logic [31:0] W_rd_data_f,
  output logic [31:0] busy_mask
);

  localparam int unsigned     CW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0]   StarveMax = CW'(STARVE_LIMIT);
  localparam logic [CW-1:0]   CntOne    = CW'(1);

  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  wb_req_t     fifo_push_data;
  wb_req_t     fifo_head;
  logic        force_pop;

  logic [CW-1:0] starve_q, starve_d;
  logic          wb_en_q, wb_en_d;
  reg_idx_t      wb_idx_q, wb_idx_d;
  logic [31:0]   wb_data_q, wb_data_d;
  logic [31:0]   busy_q, busy_d;

  assign lat_resp_ready = rst && !fifo_full;
  // Writes to x0 have no architectural effect, so they never occupy an entry.
  assign fifo_push      = lat_resp_valid && lat_resp_ready && (lat_resp_rd != REG_ZERO);
  assign fifo_push_data = '{rd: lat_resp_rd, data: lat_resp_data};

  wb_resp_fifo #(
    .DEPTH (DEPTH)
  ) u_resp_fifo (
    .clk_i       (clk),
    .rst_ni      (rst),
    .push_i      (fifo_push),
    .push_data_i (fifo_push_data),
    .pop_i       (fifo_pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (fifo_head)
  );

  assign force_pop = rst && (starve_q >= StarveMax) && !fifo_empty;

  // Write port arbitration: starved FIFO head > ALU > FIFO head.
  always_comb begin
    fifo_pop  = 1'b0;
    alu_stall = 1'b0;
    wb_en_d   = 1'b0;
    wb_idx_d  = wb_idx_q;
    wb_data_d = wb_data_q;
    if (force_pop) begin
      fifo_pop  = 1'b1;
      wb_en_d   = 1'b1;
      wb_idx_d  = fifo_head.rd;
      wb_data_d = fifo_head.data;
      alu_stall = alu_valid;
    end else if (alu_valid) begin
      if (alu_rd != REG_ZERO) begin
        wb_en_d   = 1'b1;
        wb_idx_d  = alu_rd;
        wb_data_d = alu_data;
      end
    end else if (!fifo_empty) begin
      fifo_pop  = 1'b1;
      wb_en_d   = 1'b1;
      wb_idx_d  = fifo_head.rd;
      wb_data_d = fifo_head.data;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (fifo_pop || fifo_empty) begin
      starve_d = '0;
    end else if (starve_q < StarveMax) begin
      starve_d = starve_q + CntOne;
    end
  end

  // Clear before set so a same-cycle reissue to the retiring index stays busy.
  always_comb begin
    busy_d = busy_q;
    if (fifo_pop) busy_d[fifo_head.rd] = 1'b0;
    if (lat_issue_valid && (lat_issue_rd != REG_ZERO)) busy_d[lat_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_q  <= '0;
      wb_en_q   <= 1'b0;
      wb_idx_q  <= REG_ZERO;
      wb_data_q <= '0;
      busy_q    <= '0;
    end else begin
      starve_q  <= starve_d;
      wb_en_q   <= wb_en_d;
      wb_idx_q  <= wb_idx_d;
      wb_data_q <= wb_data_d;
      busy_q    <= busy_d;
    end
  end

  assign W_wb_en_f    = wb_en_q;
  assign W_rd_index_f = wb_idx_q;
  assign W_rd_data_f  = wb_data_q;
  assign busy_mask    = busy_q;

  // Protocol violations by the surrounding pipeline; no recovery in hardware.
  a_issue_not_busy : assert property (@(posedge clk) disable iff (!rst)
    (lat_issue_valid && (lat_issue_rd != REG_ZERO)) |->
      (!busy_q[lat_issue_rd] || (fifo_pop && (fifo_head.rd == lat_issue_rd))));

  a_alu_not_busy : assert property (@(posedge clk) disable iff (!rst)
    (alu_valid && (alu_rd != REG_ZERO)) |-> !busy_q[alu_rd]);

  a_resp_was_busy : assert property (@(posedge clk) disable iff (!rst)
    (lat_resp_valid && lat_resp_ready && (lat_resp_rd != REG_ZERO)) |-> busy_q[lat_resp_rd]);

endmodule

// File: tb/tb_wb_writeback_unit.sv
module tb_wb_writeback_unit;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_stall;
  logic        lat_issue_valid = 1'b0;
  logic [4:0]  lat_issue_rd = '0;
  logic        lat_resp_valid = 1'b0;
  logic        lat_resp_ready;
  logic [4:0]  lat_resp_rd = '0;
  logic [31:0] lat_resp_data = '0;
  logic        W_wb_en_f;
  logic [4:0]  W_rd_index_f;
  logic [31:0] W_rd_data_f;
  logic [31:0] busy_mask;

  int      checks = 0;
  int      failures = 0;
  bit      mon_en = 1'b0;
  wb_req_t exp_q[$];

  always #5 clk = ~clk;

  wb_writeback_unit #(
    .DEPTH        (4),
    .STARVE_LIMIT (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .alu_valid       (alu_valid),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .alu_stall       (alu_stall),
    .lat_issue_valid (lat_issue_valid),
    .lat_issue_rd    (lat_issue_rd),
    .lat_resp_valid  (lat_resp_valid),
    .lat_resp_ready  (lat_resp_ready),
    .lat_resp_rd     (lat_resp_rd),
    .lat_resp_data   (lat_resp_data),
    .W_wb_en_f       (W_wb_en_f),
    .W_rd_index_f    (W_rd_index_f),
    .W_rd_data_f     (W_rd_data_f),
    .busy_mask       (busy_mask)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
    wb_req_t e;
    e.rd   = rd;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Check combinational outputs for the inputs already driven, record the
  // ALU write this cycle should produce, then advance one clock.
  task automatic run_cycle(input bit exp_stall, input bit exp_ready);
    #1;
    chk("alu_stall", 32'(alu_stall), 32'(exp_stall));
    chk("lat_resp_ready", 32'(lat_resp_ready), 32'(exp_ready));
    if (alu_valid && !exp_stall && alu_rd != 5'd0) expect_wr(alu_rd, alu_data);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every write on the W port must match the oldest expectation.
  always @(negedge clk) begin
    wb_req_t e;
    if (mon_en && W_wb_en_f === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_write got idx=%0d data=%h required=no write at %0t",
                 W_rd_index_f, W_rd_data_f, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wb_index", 32'(W_rd_index_f), 32'(e.rd));
        chk("wb_data", W_rd_data_f, e.data);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held two cycles with an ALU result offered.
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'h11;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_wb_en", 32'(W_wb_en_f), 32'd0);
    chk("rst_index", 32'(W_rd_index_f), 32'd0);
    chk("rst_data", W_rd_data_f, 32'd0);
    chk("rst_busy", busy_mask, 32'd0);
    chk("rst_ready", 32'(lat_resp_ready), 32'd0);
    chk("rst_stall", 32'(alu_stall), 32'd0);
    rst       = 1'b1;
    alu_valid = 1'b0;
    mon_en    = 1'b1;
    run_cycle(1'b0, 1'b1);

    // ALU path, then a write to x0 that must be suppressed.
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'hDEADBEEF;
    run_cycle(1'b0, 1'b1);
    chk("alu_wb_en", 32'(W_wb_en_f), 32'd1);
    alu_rd   = 5'd0;
    alu_data = 32'h00000BAD;
    run_cycle(1'b0, 1'b1);
    chk("x0_wb_en", 32'(W_wb_en_f), 32'd0);
    chk("x0_hold_index", 32'(W_rd_index_f), 32'd5);
    chk("x0_hold_data", W_rd_data_f, 32'hDEADBEEF);
    alu_valid = 1'b0;

    // Long-latency issue and response with the ALU idle.
    lat_issue_valid = 1'b1;
    lat_issue_rd    = 5'd7;
    run_cycle(1'b0, 1'b1);
    lat_issue_valid = 1'b0;
    chk("busy_after_issue7", busy_mask, 32'h0000_0080);
    lat_resp_valid = 1'b1;
    lat_resp_rd    = 5'd7;
    lat_resp_data  = 32'h00001234;
    expect_wr(5'd7, 32'h00001234);
    run_cycle(1'b0, 1'b1);
    lat_resp_valid = 1'b0;
    chk("resp_n1_wb_en", 32'(W_wb_en_f), 32'd0);
    run_cycle(1'b0, 1'b1);
    chk("resp_n2_wb_en", 32'(W_wb_en_f), 32'd1);
    chk("busy_after_resp7", busy_mask, 32'd0);

    // Starvation: ALU always valid, one queued response forced after 4 losses.
    lat_issue_valid = 1'b1;
    lat_issue_rd    = 5'd9;
    run_cycle(1'b0, 1'b1);
    lat_issue_valid = 1'b0;
    lat_resp_valid  = 1'b1;
    lat_resp_rd     = 5'd9;
    lat_resp_data   = 32'h0000900D;
    alu_valid       = 1'b1;
    alu_rd          = 5'd1;
    alu_data        = 32'h101;
    run_cycle(1'b0, 1'b1);
    lat_resp_valid = 1'b0;
    for (int k = 2; k <= 5; k++) begin
      alu_data = 32'h100 + 32'(k);
      run_cycle(1'b0, 1'b1);
    end
    expect_wr(5'd9, 32'h0000900D);
    alu_data = 32'h106;
    run_cycle(1'b1, 1'b1);
    chk("busy_after_force9", busy_mask, 32'd0);
    run_cycle(1'b0, 1'b1);
    chk("resume_wb_en", 32'(W_wb_en_f), 32'd1);
    alu_valid = 1'b0;

    // Backpressure: fill the FIFO behind a busy ALU, fifth response held off.
    for (int i = 0; i < 5; i++) begin
      lat_issue_valid = 1'b1;
      lat_issue_rd    = 5'(10 + i);
      run_cycle(1'b0, 1'b1);
    end
    lat_issue_valid = 1'b0;
    chk("busy_10_14", busy_mask, 32'h0000_7C00);
    alu_valid = 1'b1;
    alu_rd    = 5'd2;
    for (int i = 0; i < 4; i++) begin
      lat_resp_valid = 1'b1;
      lat_resp_rd    = 5'(10 + i);
      lat_resp_data  = 32'hA0 + 32'(i);
      alu_data       = 32'h200 + 32'(i);
      run_cycle(1'b0, 1'b1);
    end
    lat_resp_rd   = 5'd14;
    lat_resp_data = 32'hA4;
    alu_data      = 32'h204;
    run_cycle(1'b0, 1'b0);
    // Forced pop while full: the held response must still be refused.
    expect_wr(5'd10, 32'hA0);
    alu_data = 32'h205;
    run_cycle(1'b1, 1'b0);
    run_cycle(1'b0, 1'b1);
    lat_resp_valid = 1'b0;
    alu_valid      = 1'b0;
    expect_wr(5'd11, 32'hA1);
    expect_wr(5'd12, 32'hA2);
    expect_wr(5'd13, 32'hA3);
    expect_wr(5'd14, 32'hA4);
    run_cycle(1'b0, 1'b0);
    run_cycle(1'b0, 1'b1);
    run_cycle(1'b0, 1'b1);
    run_cycle(1'b0, 1'b1);
    chk("busy_after_drain", busy_mask, 32'd0);
    run_cycle(1'b0, 1'b1);

    // Set/clear race: reissue to x3 in the cycle its response retires.
    lat_issue_valid = 1'b1;
    lat_issue_rd    = 5'd3;
    run_cycle(1'b0, 1'b1);
    lat_issue_valid = 1'b0;
    lat_resp_valid  = 1'b1;
    lat_resp_rd     = 5'd3;
    lat_resp_data   = 32'h33;
    expect_wr(5'd3, 32'h33);
    run_cycle(1'b0, 1'b1);
    lat_resp_valid  = 1'b0;
    lat_issue_valid = 1'b1;
    lat_issue_rd    = 5'd3;
    run_cycle(1'b0, 1'b1);
    lat_issue_valid = 1'b0;
    chk("race_busy3", busy_mask, 32'h0000_0008);

    // Reset with two responses still queued behind the ALU.
    lat_issue_valid = 1'b1;
    lat_issue_rd    = 5'd20;
    run_cycle(1'b0, 1'b1);
    lat_issue_rd = 5'd21;
    run_cycle(1'b0, 1'b1);
    lat_issue_valid = 1'b0;
    alu_valid       = 1'b1;
    alu_rd          = 5'd4;
    alu_data        = 32'h400;
    lat_resp_valid  = 1'b1;
    lat_resp_rd     = 5'd20;
    lat_resp_data   = 32'h2000;
    run_cycle(1'b0, 1'b1);
    alu_data      = 32'h401;
    lat_resp_rd   = 5'd21;
    lat_resp_data = 32'h2100;
    run_cycle(1'b0, 1'b1);
    lat_resp_valid = 1'b0;
    alu_valid      = 1'b0;
    rst            = 1'b0;
    run_cycle(1'b0, 1'b0);
    chk("midrst_wb_en", 32'(W_wb_en_f), 32'd0);
    chk("midrst_busy", busy_mask, 32'd0);
    run_cycle(1'b0, 1'b0);
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_cycle(1'b0, 1'b1);
      chk("postrst_wb_en", 32'(W_wb_en_f), 32'd0);
    end
    chk("postrst_busy", busy_mask, 32'd0);
    chk("pending_expected_writes", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
